mem_request_unit: RTL and testbench
===================================

Name: mem_request_unit

Overview:
- Sits directly upstream of the memory/peripheral bus block, between the CPU core and the bus.
- Arbitrates between the instruction-fetch port and the load/store port.
- Translates each CPU access into one bus transaction (address, byte count, write data, start/done handshake).
- Formats load results: sign/zero extension for LB/LH/LW/LBU/LHU.
- Raises faults for misaligned, out-of-range, flash-write and timed-out accesses.

Parameters:
- address_size, 18: bus address width. Bit [address_size-1]=1 selects IO; bit [address_size-2]=1 selects RAM, 0 selects flash.
- timeout_cycles, 4096: cycles to wait for bus_request_done before faulting. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fetch_req  in  1  instruction fetch request, held until fetch_done
- fetch_addr  in  32  fetch byte address
- fetch_done  out  1  one-cycle pulse: fetch_instr valid or fetch_fault set
- fetch_instr  out  32  fetched instruction word
- fetch_fault  out  1  valid with fetch_done
- data_req  in  1  load/store request, held until data_done
- data_we  in  1  1 = store
- data_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, LSB-aligned
- data_done  out  1  one-cycle completion pulse
- data_rdata  out  32  extended load result
- data_fault  out  1  valid with data_done
- bus_target_address  out  address_size  bus address
- bus_num_bytes  out  3  1, 2 or 4
- bus_is_write  out  1  write strobe
- bus_write_value  out  32  store data
- bus_start_request  out  1  held high until bus_request_done is seen
- bus_fetched_value  in  32  little-endian; low 8*n bits valid
- bus_request_done  in  1  level; stays high while bus_start_request is high

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM=IDLE, timeout counter=0. Reset mid-transaction drops bus_start_request on the same edge; no done pulse is issued.
- FSM states:
  - IDLE: if data_req, latch data operands, grant data (data wins on simultaneous requests); else if fetch_req, latch fetch operands, grant fetch. Run checks. Check fails -> FAULT. Otherwise drive bus_* registers, set bus_start_request, go ISSUE.
  - ISSUE: bus_start_request=1, counter increments. On bus_request_done=1: capture bus_fetched_value, clear bus_start_request, go RELEASE. On counter reaching timeout_cycles (when nonzero): clear bus_start_request, set fault, go RELEASE.
  - RELEASE: bus_start_request=0. Wait until bus_request_done=0 (minimum one cycle), then pulse the granted done for one cycle with result/fault, go WAIT_DROP.
  - FAULT: pulse the granted done with fault=1 for one cycle, go WAIT_DROP.
  - WAIT_DROP: stay until the granted req is 0, then IDLE. Prevents double issue.
- Checks:
  - addr[31:address_size] != 0 -> fault.
  - H/HU with addr[0]=1 -> fault.
  - W with addr[1:0] != 0 -> fault.
  - Fetch with addr[1:0] != 0 -> fault.
  - Store where addr[address_size-1:address_size-2]=00 (flash) -> fault.
  - Any funct3 other than the five listed -> fault.
- Bus mapping:
  - bus_target_address = addr[address_size-1:0].
  - bus_num_bytes = 1/2/4 from funct3; fetch always 4.
  - bus_is_write = data_we for data accesses, 0 for fetch.
  - bus_write_value = data_wdata, masked to the access size (upper bytes zeroed).
- Load formatting: B sign-extends bits [7:0]; H sign-extends bits [15:0]; BU and HU zero-extend; W is a passthrough. Fetch is a passthrough.
- data_rdata and fetch_instr hold their last value until the next done. data_rdata is 0 on fault.
- Minimum latency, req to done: 1 (IDLE) + ISSUE cycles + 1 (RELEASE). A fault detected in IDLE completes in 2 cycles.
- No bus_* output other than bus_start_request changes while in ISSUE.

Decomposition:
- Shared package (mcu_pkg):
  - funct3 load/store constants.
  - FSM state encoding: one-hot, 5 bits.
  - Memory-map region constants: REGION_FLASH=2'b00, REGION_RAM=2'b01, REGION_IO=2'b1x.
- One natural sub-module: load_formatter. Combinational sign/zero extension taking funct3 and the raw value; reused by the core's writeback stage.

Test Plan:
- LB at 0x00010003, bus returns 0x000000F0 -> bus_target_address=0x10003, bus_num_bytes=1, data_rdata=0xFFFFFFF0, data_fault=0.
- LHU at 0x00010002, bus returns 0xABCD8001 -> bus_num_bytes=2, data_rdata=0x00008001.
- SW 0x12345678 at 0x00010002 -> bus_start_request never asserts; data_done pulses with data_fault=1 two cycles after data_req. SB to 0x00000004 (flash) -> data_fault=1.
- fetch_req and data_req (store to 0x00020010, wdata 0x3) raised on the same cycle -> data transaction issued first, bus_target_address=0x20010, bus_is_write=1, bus_num_bytes=4. Fetch is issued only after data_req drops.
- timeout_cycles=8, bus_request_done held 0 -> bus_start_request drops after 8 ISSUE cycles; fetch_done pulses with fetch_fault=1.
- rst asserted during ISSUE -> bus_start_request=0 on the next edge, no done pulse. A fresh fetch of 0x00000000 after reset completes normally.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared constants for the memory request path: RV32 load/store funct3 codes,
// request FSM encoding and memory-map regions.
package mcu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_ISSUE     = 5'b00010,
        ST_RELEASE   = 5'b00100,
        ST_FAULT     = 5'b01000,
        ST_WAIT_DROP = 5'b10000
    } req_state_e;

    // IO is any region with the top bit set (2'b1x); region_of folds it to 2'b10.
    localparam logic [1:0] REGION_FLASH = 2'b00;
    localparam logic [1:0] REGION_RAM   = 2'b01;
    localparam logic [1:0] REGION_IO    = 2'b10;

    function automatic logic [1:0] region_of(input logic [1:0] top_bits);
        return top_bits[1] ? REGION_IO : (top_bits[0] ? REGION_RAM : REGION_FLASH);
    endfunction

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] num_bytes);
        case (num_bytes)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Bus-side handshake of the memory request unit: one transaction at a time,
// start held until done is seen, done level-held while start is high.
interface mem_request_unit_if #(
    parameter int unsigned address_size = 18
);
    logic [address_size-1:0] bus_target_address;
    logic [2:0]              bus_num_bytes;
    logic                    bus_is_write;
    logic [31:0]             bus_write_value;
    logic                    bus_start_request;
    logic [31:0]             bus_fetched_value;
    logic                    bus_request_done;

    modport master (
        output bus_target_address,
        output bus_num_bytes,
        output bus_is_write,
        output bus_write_value,
        output bus_start_request,
        input  bus_fetched_value,
        input  bus_request_done
    );

    modport slave (
        input  bus_target_address,
        input  bus_num_bytes,
        input  bus_is_write,
        input  bus_write_value,
        input  bus_start_request,
        output bus_fetched_value,
        output bus_request_done
    );
endinterface

// File: rtl/load_formatter.sv
// Sign/zero extension of a little-endian bus read according to RV32 load funct3.
module load_formatter
    import mcu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    always_comb begin
        value = raw;
        case (funct3)
            F3_B:    value = {{24{raw[7]}}, raw[7:0]};
            F3_H:    value = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   value = {24'd0, raw[7:0]};
            F3_HU:   value = {16'd0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/mem_request_unit.sv
// Arbitrates fetch and load/store requests onto a single bus, one transaction
// at a time, with access checking, timeout and load result formatting.
module mem_request_unit
    import mcu_pkg::*;
#(
    parameter int unsigned address_size   = 18,
    parameter int unsigned timeout_cycles = 4096
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_instr,
    output logic        fetch_fault,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [2:0]  data_funct3,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        data_fault,

    mem_request_unit_if.master bus
);

    req_state_e              state_q, state_d;
    logic                    grant_data_q, grant_data_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    tfault_q, tfault_d;
    logic [31:0]             raw_q, raw_d;

    logic [address_size-1:0] addr_q, addr_d;
    logic [2:0]              nbytes_q, nbytes_d;
    logic                    is_write_q, is_write_d;
    logic [31:0]             wval_q, wval_d;
    logic                    start_q, start_d;

    logic                    fetch_done_q, fetch_done_d;
    logic [31:0]             fetch_instr_q, fetch_instr_d;
    logic                    fetch_fault_q, fetch_fault_d;
    logic                    data_done_q, data_done_d;
    logic [31:0]             data_rdata_q, data_rdata_d;
    logic                    data_fault_q, data_fault_d;

    logic                    use_data;
    logic [31:0]             req_addr;
    logic [2:0]              req_f3;
    logic                    req_we;
    logic                    chk_fault;
    logic                    granted_req;
    logic [31:0]             fmt_value;

    load_formatter u_fmt (
        .funct3 (funct3_q),
        .raw    (raw_q),
        .value  (fmt_value)
    );

    // Operand mux for the IDLE decision: data wins, fetch is treated as LW.
    always_comb begin
        use_data = data_req;
        req_addr = use_data ? data_addr : fetch_addr;
        req_f3   = use_data ? data_funct3 : F3_W;
        req_we   = use_data & data_we;

        chk_fault = 1'b0;
        if ((req_addr >> address_size) != 32'd0)
            chk_fault = 1'b1;
        if (((req_f3 == F3_H) || (req_f3 == F3_HU)) && req_addr[0])
            chk_fault = 1'b1;
        if ((req_f3 == F3_W) && (req_addr[1:0] != 2'b00))
            chk_fault = 1'b1;
        if (!f3_valid(req_f3))
            chk_fault = 1'b1;
        if (req_we && (region_of(req_addr[address_size-1 -: 2]) == REGION_FLASH))
            chk_fault = 1'b1;

        granted_req = grant_data_q ? data_req : fetch_req;
    end

    always_comb begin
        state_d       = state_q;
        grant_data_d  = grant_data_q;
        funct3_d      = funct3_q;
        cnt_d         = cnt_q;
        tfault_d      = tfault_q;
        raw_d         = raw_q;
        addr_d        = addr_q;
        nbytes_d      = nbytes_q;
        is_write_d    = is_write_q;
        wval_d        = wval_q;
        start_d       = start_q;
        fetch_done_d  = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;
        data_done_d   = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_fault_d  = data_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (data_req || fetch_req) begin
                    grant_data_d = use_data;
                    funct3_d     = req_f3;
                    cnt_d        = '0;
                    tfault_d     = 1'b0;
                    if (chk_fault) begin
                        state_d = ST_FAULT;
                    end else begin
                        addr_d     = req_addr[address_size-1:0];
                        nbytes_d   = f3_bytes(req_f3);
                        is_write_d = req_we;
                        wval_d     = use_data ? (data_wdata & size_mask(f3_bytes(req_f3))) : '0;
                        start_d    = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (bus.bus_request_done) begin
                    raw_d   = bus.bus_fetched_value;
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if ((timeout_cycles != 0) && (cnt_d == timeout_cycles)) begin
                    start_d  = 1'b0;
                    tfault_d = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (!bus.bus_request_done) begin
                    if (grant_data_q) begin
                        data_done_d  = 1'b1;
                        data_fault_d = tfault_q;
                        data_rdata_d = tfault_q ? '0 : fmt_value;
                    end else begin
                        fetch_done_d  = 1'b1;
                        fetch_fault_d = tfault_q;
                        fetch_instr_d = tfault_q ? '0 : raw_q;
                    end
                    state_d = ST_WAIT_DROP;
                end
            end

            ST_FAULT: begin
                if (grant_data_q) begin
                    data_done_d  = 1'b1;
                    data_fault_d = 1'b1;
                    data_rdata_d = '0;
                end else begin
                    fetch_done_d  = 1'b1;
                    fetch_fault_d = 1'b1;
                    fetch_instr_d = '0;
                end
                state_d = ST_WAIT_DROP;
            end

            ST_WAIT_DROP: begin
                if (!granted_req)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_data_q  <= 1'b0;
            funct3_q      <= '0;
            cnt_q         <= '0;
            tfault_q      <= 1'b0;
            raw_q         <= '0;
            addr_q        <= '0;
            nbytes_q      <= '0;
            is_write_q    <= 1'b0;
            wval_q        <= '0;
            start_q       <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_instr_q <= '0;
            fetch_fault_q <= 1'b0;
            data_done_q   <= 1'b0;
            data_rdata_q  <= '0;
            data_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_data_q  <= grant_data_d;
            funct3_q      <= funct3_d;
            cnt_q         <= cnt_d;
            tfault_q      <= tfault_d;
            raw_q         <= raw_d;
            addr_q        <= addr_d;
            nbytes_q      <= nbytes_d;
            is_write_q    <= is_write_d;
            wval_q        <= wval_d;
            start_q       <= start_d;
            fetch_done_q  <= fetch_done_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
            data_done_q   <= data_done_d;
            data_rdata_q  <= data_rdata_d;
            data_fault_q  <= data_fault_d;
        end
    end

    assign bus.bus_target_address = addr_q;
    assign bus.bus_num_bytes      = nbytes_q;
    assign bus.bus_is_write       = is_write_q;
    assign bus.bus_write_value    = wval_q;
    assign bus.bus_start_request  = start_q;

    assign fetch_done  = fetch_done_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;
    assign data_done   = data_done_q;
    assign data_rdata  = data_rdata_q;
    assign data_fault  = data_fault_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: loads/stores, access faults, arbitration,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_mem_request_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        data_req;
    logic        data_we;
    logic [2:0]  data_funct3;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        data_fault;

    int errors = 0;
    int checks = 0;
    int n;

    mem_request_unit_if #(.address_size(18)) bus_if ();

    mem_request_unit #(
        .address_size   (18),
        .timeout_cycles (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_done  (fetch_done),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_funct3 (data_funct3),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_done   (data_done),
        .data_rdata  (data_rdata),
        .data_fault  (data_fault),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Successful data access with an immediate bus response.
    task automatic data_xact(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rval, input logic [31:0] exp_addr,
                             input logic [31:0] exp_nb, input logic [31:0] exp_wv,
                             input logic [31:0] exp_rd);
        data_req = 1'b1; data_we = we; data_funct3 = f3; data_addr = addr; data_wdata = wdata;
        step();
        chk({tag, " start"}, {31'd0, bus_if.bus_start_request}, 32'd1);
        chk({tag, " addr"},  {14'd0, bus_if.bus_target_address}, exp_addr);
        chk({tag, " nbytes"}, {29'd0, bus_if.bus_num_bytes}, exp_nb);
        chk({tag, " is_write"}, {31'd0, bus_if.bus_is_write}, {31'd0, we});
        chk({tag, " wval"}, bus_if.bus_write_value, exp_wv);
        bus_if.bus_fetched_value = rval;
        bus_if.bus_request_done  = 1'b1;
        step();
        chk({tag, " start dropped"}, {31'd0, bus_if.bus_start_request}, 32'd0);
        chk({tag, " no early done"}, {31'd0, data_done}, 32'd0);
        bus_if.bus_request_done = 1'b0;
        step();
        chk({tag, " done"}, {31'd0, data_done}, 32'd1);
        chk({tag, " fault"}, {31'd0, data_fault}, 32'd0);
        chk({tag, " rdata"}, data_rdata, exp_rd);
        data_req = 1'b0;
        step();
        chk({tag, " done pulse"}, {31'd0, data_done}, 32'd0);
    endtask

    // Data access rejected in IDLE: done+fault two edges after the request.
    task automatic data_fault_xact(input string tag, input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        data_req = 1'b1; data_we = we; data_funct3 = f3; data_addr = addr; data_wdata = wdata;
        step();
        chk({tag, " no start 1"}, {31'd0, bus_if.bus_start_request}, 32'd0);
        chk({tag, " no done 1"}, {31'd0, data_done}, 32'd0);
        step();
        chk({tag, " no start 2"}, {31'd0, bus_if.bus_start_request}, 32'd0);
        chk({tag, " done"}, {31'd0, data_done}, 32'd1);
        chk({tag, " fault"}, {31'd0, data_fault}, 32'd1);
        chk({tag, " rdata"}, data_rdata, 32'd0);
        data_req = 1'b0;
        step();
        chk({tag, " done pulse"}, {31'd0, data_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_funct3 = '0; data_addr = '0; data_wdata = '0;
        bus_if.bus_fetched_value = '0;
        bus_if.bus_request_done  = 1'b0;
        step();
        step();
        chk("reset start", {31'd0, bus_if.bus_start_request}, 32'd0);
        chk("reset addr", {14'd0, bus_if.bus_target_address}, 32'd0);
        chk("reset fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("reset data_done", {31'd0, data_done}, 32'd0);
        chk("reset rdata", data_rdata, 32'd0);
        rst = 1'b0;
        step();

        data_xact("LB",  1'b0, 3'b000, 32'h0001_0003, 32'h0, 32'h0000_00F0,
                  32'h10003, 32'd1, 32'h0, 32'hFFFF_FFF0);
        data_xact("LHU", 1'b0, 3'b101, 32'h0001_0002, 32'h0, 32'hABCD_8001,
                  32'h10002, 32'd2, 32'h0, 32'h0000_8001);
        data_xact("LH",  1'b0, 3'b001, 32'h0001_0002, 32'h0, 32'hABCD_8001,
                  32'h10002, 32'd2, 32'h0, 32'hFFFF_8001);
        data_xact("LBU", 1'b0, 3'b100, 32'h0001_0001, 32'h0, 32'h1234_56A5,
                  32'h10001, 32'd1, 32'h0, 32'h0000_00A5);
        data_xact("LW",  1'b0, 3'b010, 32'h0001_0004, 32'h0, 32'h8000_0001,
                  32'h10004, 32'd4, 32'h0, 32'h8000_0001);
        data_xact("SB",  1'b1, 3'b000, 32'h0001_0001, 32'hAABB_CCDD, 32'h0,
                  32'h10001, 32'd1, 32'h0000_00DD, 32'h0);
        data_xact("SH",  1'b1, 3'b001, 32'h0001_0002, 32'hAABB_CCDD, 32'h0,
                  32'h10002, 32'd2, 32'h0000_CCDD, 32'h0);

        data_fault_xact("SW misaligned", 1'b1, 3'b010, 32'h0001_0002, 32'h1234_5678);
        data_fault_xact("SB flash",      1'b1, 3'b000, 32'h0000_0004, 32'h0000_0055);
        data_fault_xact("LW out of range", 1'b0, 3'b010, 32'h0004_0000, 32'h0);
        data_fault_xact("LH odd",        1'b0, 3'b001, 32'h0001_0001, 32'h0);
        data_fault_xact("bad funct3",    1'b0, 3'b011, 32'h0001_0000, 32'h0);

        // Misaligned fetch faults without touching the bus.
        fetch_req = 1'b1; fetch_addr = 32'h0001_0002;
        step();
        chk("fetch misaligned no start", {31'd0, bus_if.bus_start_request}, 32'd0);
        step();
        chk("fetch misaligned done", {31'd0, fetch_done}, 32'd1);
        chk("fetch misaligned fault", {31'd0, fetch_fault}, 32'd1);
        fetch_req = 1'b0;
        step();

        // Simultaneous requests: store goes first, fetch waits for data_req to drop.
        fetch_req = 1'b1; fetch_addr = 32'h0001_0040;
        data_req = 1'b1; data_we = 1'b1; data_funct3 = 3'b010;
        data_addr = 32'h0002_0010; data_wdata = 32'h0000_0003;
        step();
        chk("arb start", {31'd0, bus_if.bus_start_request}, 32'd1);
        chk("arb addr", {14'd0, bus_if.bus_target_address}, 32'h20010);
        chk("arb is_write", {31'd0, bus_if.bus_is_write}, 32'd1);
        chk("arb nbytes", {29'd0, bus_if.bus_num_bytes}, 32'd4);
        chk("arb wval", bus_if.bus_write_value, 32'h3);
        bus_if.bus_request_done = 1'b1;
        step();
        bus_if.bus_request_done = 1'b0;
        step();
        chk("arb data_done", {31'd0, data_done}, 32'd1);
        chk("arb data_fault", {31'd0, data_fault}, 32'd0);
        chk("arb no fetch_done", {31'd0, fetch_done}, 32'd0);
        step();
        chk("arb hold while data_req", {31'd0, bus_if.bus_start_request}, 32'd0);
        data_req = 1'b0;
        step();
        chk("arb idle", {31'd0, bus_if.bus_start_request}, 32'd0);
        step();
        chk("arb fetch start", {31'd0, bus_if.bus_start_request}, 32'd1);
        chk("arb fetch addr", {14'd0, bus_if.bus_target_address}, 32'h10040);
        chk("arb fetch is_write", {31'd0, bus_if.bus_is_write}, 32'd0);
        chk("arb fetch nbytes", {29'd0, bus_if.bus_num_bytes}, 32'd4);
        bus_if.bus_fetched_value = 32'h0000_0013;
        bus_if.bus_request_done  = 1'b1;
        step();
        bus_if.bus_request_done = 1'b0;
        step();
        chk("arb fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("arb fetch_instr", fetch_instr, 32'h0000_0013);
        chk("arb fetch_fault", {31'd0, fetch_fault}, 32'd0);
        fetch_req = 1'b0;
        step();

        // Timeout: no bus response, start held for exactly 8 cycles.
        fetch_req = 1'b1; fetch_addr = 32'h0001_0000;
        step();
        chk("timeout start", {31'd0, bus_if.bus_start_request}, 32'd1);
        n = 0;
        while (bus_if.bus_start_request && n < 20) begin
            step();
            n++;
        end
        chk("timeout issue cycles", n, 32'd8);
        chk("timeout no early done", {31'd0, fetch_done}, 32'd0);
        step();
        chk("timeout fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("timeout fetch_fault", {31'd0, fetch_fault}, 32'd1);
        fetch_req = 1'b0;
        step();

        // Reset during ISSUE, then a clean fetch from flash address 0.
        fetch_req = 1'b1; fetch_addr = 32'h0001_0010;
        step();
        step();
        chk("rst pre start", {31'd0, bus_if.bus_start_request}, 32'd1);
        rst = 1'b1;
        step();
        chk("rst drops start", {31'd0, bus_if.bus_start_request}, 32'd0);
        chk("rst no fetch_done", {31'd0, fetch_done}, 32'd0);
        rst = 1'b0; fetch_req = 1'b0;
        step();
        chk("rst after no fetch_done", {31'd0, fetch_done}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0000;
        step();
        chk("fresh start", {31'd0, bus_if.bus_start_request}, 32'd1);
        chk("fresh addr", {14'd0, bus_if.bus_target_address}, 32'h0);
        bus_if.bus_fetched_value = 32'hDEAD_BEEF;
        bus_if.bus_request_done  = 1'b1;
        step();
        bus_if.bus_request_done = 1'b0;
        step();
        chk("fresh fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("fresh fetch_instr", fetch_instr, 32'hDEAD_BEEF);
        chk("fresh fetch_fault", {31'd0, fetch_fault}, 32'd0);
        fetch_req = 1'b0;
        step();
        chk("fresh done pulse", {31'd0, fetch_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
